// File: rtl/quad_step_pkg.sv
// Shared types for the quadrature step decoder: phase encoding, FSM states, Gray codes.
// Pure declarations; no logic, no latency, no backpressure.
package quad_step_pkg;

    typedef logic [1:0] phase_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam phase_t PH_00 = 2'b00;
    localparam phase_t PH_01 = 2'b01;
    localparam phase_t PH_11 = 2'b11;
    localparam phase_t PH_10 = 2'b10;

endpackage

// File: rtl/quad_input_filter.sv
// One channel: 2-flop synchroniser plus stability filter; the counter doubles as the INIT timer.
// Latency: raw edge to filt is FILTER_CYCLES+1 edges; no backpressure (free-running).
module quad_input_filter #(
    parameter int FILTER_CYCLES = 4,
    localparam int CNT_W = $clog2(FILTER_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic init,
    input  logic tick,
    output logic sync,
    output logic filt,
    output logic timer_done
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMER_END = CNT_W'(FILTER_CYCLES);

    logic             sync1;
    logic             sync2;
    logic             filt_q;
    logic [CNT_W-1:0] cnt;

    assign sync       = sync2;
    assign filt       = filt_q;
    assign timer_done = init && tick && (cnt == TIMER_END);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            filt_q <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (init) begin
                // Timer mode: filt is loaded directly from the synchroniser at the end.
                if (tick) begin
                    if (cnt == TIMER_END) begin
                        filt_q <= sync2;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            end else if (sync2 == filt_q) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                filt_q <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature A/B to clean one-cycle up/down/err pulses via sync, filter and Gray decoder.
// Latency: raw edge to pulse is FILTER_CYCLES+2 edges; no backpressure (pulses are fire-and-forget).
module quad_step_decoder
    import quad_step_pkg::*;
#(
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enc_a,
    input  logic enc_b,
    output logic up,
    output logic down,
    output logic err
);

    state_t state_q, state_d;
    phase_t prev_q, prev_d;
    phase_t phase;
    logic   up_d, down_d, err_d;
    logic   filt_a, filt_b, sync_a, sync_b;
    logic   done_a, done_b;
    logic   init;
    logic   timer_arm;

    assign init  = (state_q == INIT);
    assign phase = {filt_a, filt_b};

    quad_input_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_a (
        .clk(clk), .reset(reset), .raw(enc_a), .init(init), .tick(timer_arm),
        .sync(sync_a), .filt(filt_a), .timer_done(done_a)
    );

    quad_input_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_b (
        .clk(clk), .reset(reset), .raw(enc_b), .init(init), .tick(timer_arm),
        .sync(sync_b), .filt(filt_b), .timer_done(done_b)
    );

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        up_d    = 1'b0;
        down_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            INIT: begin
                if (done_a && done_b) begin
                    state_d = RUN;
                    prev_d  = {sync_a, sync_b};
                end
            end
            RUN: begin
                prev_d = phase;
                if ((prev_q ^ phase) == 2'b11) begin
                    err_d = 1'b1;
                end else begin
                    case ({prev_q, phase})
                        {PH_00, PH_01}, {PH_01, PH_11},
                        {PH_11, PH_10}, {PH_10, PH_00}: up_d   = 1'b1;
                        {PH_00, PH_10}, {PH_10, PH_11},
                        {PH_11, PH_01}, {PH_01, PH_00}: down_d = 1'b1;
                        default: ;
                    endcase
                end
            end
            default: state_d = INIT;
        endcase
    end

    // timer_arm delays the INIT timer by one edge so INIT spans FILTER_CYCLES+2 edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= INIT;
            prev_q    <= PH_00;
            up        <= 1'b0;
            down      <= 1'b0;
            err       <= 1'b0;
            timer_arm <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            up        <= up_d;
            down      <= down_d;
            err       <= err_d;
            timer_arm <= 1'b1;
        end
    end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboard bench: stimulus pushes expected pulse (kind, cycle); a negedge monitor pops and compares.
module tb_quad_step_decoder;

    localparam int FC  = 4;
    localparam int LAT = FC + 2;
    localparam logic [2:0] K_NONE = 3'b000;
    localparam logic [2:0] K_UP   = 3'b100;
    localparam logic [2:0] K_DN   = 3'b010;
    localparam logic [2:0] K_ER   = 3'b001;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic enc_a = 1'b0;
    logic enc_b = 1'b0;
    logic up, down, err;

    typedef struct {
        int         cyc;
        logic [2:0] kind;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    quad_step_decoder #(.FILTER_CYCLES(FC)) dut (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
        .up(up), .down(down), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every pulse cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        if (up || down || err) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got {up,down,err}=%b at cyc %0d, required no pulse",
                         {up, down, err}, cyc);
            end else begin
                e = sb.pop_front();
                if (e.kind !== {up, down, err} || e.cyc != cyc) begin
                    errors++;
                    $display("FAIL pulse: got {up,down,err}=%b at cyc %0d, required %b at cyc %0d",
                             {up, down, err}, cyc, e.kind, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Drive a new phase at a negedge; the next posedge is the first sampling edge.
    task automatic step(input logic a, input logic b, input logic [2:0] kind, input int hold);
        @(negedge clk);
        enc_a = a;
        enc_b = b;
        if (kind != K_NONE) sb.push_back('{cyc + 1 + LAT, kind});
        repeat (hold) @(negedge clk);
    endtask

    initial begin
        // Reset with a non-zero rest position; no pulses may appear after release.
        enc_a = 1'b1;
        enc_b = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs", 32'({up, down, err}), 32'(K_NONE));
        end
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("settle_phase_11", 32'(dut.phase), 32'h3);

        // Walk from 11 back to 00 with forward steps.
        step(1'b1, 1'b0, K_UP, 10);
        step(1'b0, 1'b0, K_UP, 10);

        // Forward 00->01->11->10->00
        step(1'b0, 1'b1, K_UP, 10);
        step(1'b1, 1'b1, K_UP, 10);
        step(1'b1, 1'b0, K_UP, 10);
        step(1'b0, 1'b0, K_UP, 10);

        // Reverse 00->10->11->01->00
        step(1'b1, 1'b0, K_DN, 10);
        step(1'b1, 1'b1, K_DN, 10);
        step(1'b0, 1'b1, K_DN, 10);
        step(1'b0, 1'b0, K_DN, 10);

        // Bounce on A shorter than the filter window.
        @(negedge clk);
        enc_a = 1'b1;
        repeat (3) @(negedge clk);
        enc_a = 1'b0;
        repeat (10) @(negedge clk);
        chk("bounce_filt_a", 32'(dut.u_filt_a.filt), 32'h0);
        chk("bounce_phase", 32'(dut.phase), 32'h0);

        // Simultaneous double change, then a legal forward step from 11.
        step(1'b1, 1'b1, K_ER, 10);
        step(1'b1, 1'b0, K_UP, 10);

        // Reset two cycles into the 10->00 transition: that step must vanish.
        @(negedge clk);
        enc_a = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_outputs", 32'({up, down, err}), 32'(K_NONE));
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("midreset_phase", 32'(dut.phase), 32'h0);
        step(1'b0, 1'b1, K_UP, 10);
        step(1'b1, 1'b1, K_UP, 10);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_pulses: got %0d outstanding, required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
- Upstream stage of the up/down counter. Converts two raw, asynchronous, bouncy quadrature inputs (A/B) into clean one-cycle up/down step pulses.
- up and down connect directly to the counter's up/down inputs.
- Stages: per-channel synchroniser, stability filter, Gray-sequence direction decoder.
- Also flags illegal (two-bit) phase jumps.

Parameters:
- FILTER_CYCLES, 4, consecutive cycles a synchronised input must differ from its filtered value before the filtered value changes (legal range 1..255).
- CNT_W, $clog2(FILTER_CYCLES+1), width of the filter counter; derived, never overridden.

Ports:
- clk    in   1  system clock; all logic on posedge
- reset  in   1  synchronous, active-high reset
- enc_a  in   1  raw quadrature channel A, asynchronous to clk
- enc_b  in   1  raw quadrature channel B, asynchronous to clk
- up     out  1  one-cycle pulse, one forward step
- down   out  1  one-cycle pulse, one reverse step
- err    out  1  one-cycle pulse, illegal phase jump (both channels changed)

Behaviour:
- Single clock, synchronous active-high reset. While reset=1 at a posedge, all of the following clear:
  - sync flops, filtered values, filter counters, prev phase: 0
  - up, down, err: 0
  - FSM: INIT
- Synchroniser: 2 flops per channel (sync1, sync2).
- Filter, per channel:
  - When sync2 == filt, cnt <= 0.
  - Otherwise cnt increments.
  - At the edge where cnt == FILTER_CYCLES-1 and sync2 != filt: filt <= sync2 and cnt <= 0.
  - A mismatch shorter than FILTER_CYCLES cycles never reaches filt.
- phase = {filt_a, filt_b}.
- FSM states: INIT, RUN.
  - INIT lasts exactly FILTER_CYCLES+2 cycles after reset deasserts, counted by the filter counter logic reused as a timer.
  - On the last INIT edge: filt_a/filt_b <= sync2 values, prev <= same phase, go to RUN.
  - No up/down/err is generated in INIT. A non-zero rest position at power-up therefore never produces a spurious pulse.
- RUN, each edge, prev <= phase and outputs are registered from the comparison of prev and phase:
  - Forward sequence 00->01->11->10->00: up=1
  - Reverse sequence 00->10->11->01->00: down=1
  - No change: all outputs 0
  - Both bits change (00<->11, 01<->10): err=1, up=down=0; prev still updates to the new phase
- up, down and err are mutually exclusive and are never high for two consecutive cycles from a single transition.
- Latency: a raw edge first sampled at posedge 0 produces the pulse high from posedge FILTER_CYCLES+2 to posedge FILTER_CYCLES+3. Example: FILTER_CYCLES=4 gives a pulse after edge 6.
- Filter independence: the two channels filter independently. If A and B raw edges are closer than one cycle, they can resolve in the same cycle, which produces err; this is the required behaviour.
- Reset mid-operation: outputs 0 at the reset edge; INIT re-runs; no pulse for any transition in flight.
- Max step rate: one legal step per FILTER_CYCLES+1 cycles. Faster input is filtered and may give err.

Decomposition:
- Package quad_step_pkg:
  - typedef logic [1:0] phase_t
  - enum state_t {INIT, RUN}
  - localparams for the four Gray phase codes (PH_00, PH_01, PH_11, PH_10)
- Sub-module quad_input_filter:
  - contents: 2-flop synchroniser, stability counter, filtered output, load-on-init input
  - instantiated once per channel
- Top level holds the FSM and the decoder.

Test Plan (FILTER_CYCLES=4):
- Reset, hold A=B=1, release reset, hold 20 cycles -> up=down=err=0 throughout; phase settles at 11.
- Forward 00->01->11->10->00, each phase held 10 cycles -> exactly 4 up pulses of 1 cycle each, first pulse high after edge 6 from the first sampling edge; down=err=0.
- Reverse 00->10->11->01->00 -> exactly 4 down pulses; up=err=0.
- Bounce: A toggles 0->1 for 3 cycles then back to 0, B held -> no pulses, filt_a stays 0.
- At phase 00, A and B both rise in the same cycle and hold -> exactly one err pulse; up=down=0; the next forward step from 11 (to 10) gives an up pulse.
- Assert reset for 1 cycle mid-forward-sequence, 2 cycles after A changes -> outputs 0 from the reset edge; no pulse for that transition; INIT runs 6 cycles, then normal decoding resumes.
